// File: rtl/hud_glyph_fetch_sched.sv
// hud_glyph_fetch_sched
//   Shares one synchronous "numbers" glyph ROM among the 12 sidebar digit
//   slots. During horizontal blanking it finds the digit tiles on the next
//   scan line, fetches their 32-pixel glyph rows into a two-bank line
//   buffer, and serves that buffer combinationally during active video.
//
// Ports
//   Clk         system clock (also clocks the glyph ROM)
//   Reset_n     asynchronous active-low reset
//   line_start  one-cycle pulse at DrawX==640; samples next_y
//   next_y      scan line displayed next
//   slot_digit  packed digit codes, slot i at [4i+3:4i]
//   rom_addr    {digit[3:0], x[4:0], y[4:0]} to the numbers ROM
//   rom_q       ROM data, valid ROM_LAT cycles after rom_addr
//   rd_x        current DrawX
//   rd_rgb      buffered glyph pixel, 0 when rd_hit=0
//   rd_hit      rd_x lies in a column holding a valid digit tile
//   busy        fetch sequence in progress
//   done        one-cycle pulse when the line buffer is complete
//   overrun     sticky: line_start arrived while busy
//
// state | meaning
// IDLE  | waiting for line_start
// SCAN  | one slot per cycle, claim banks whose tile row matches
// FETCH | 32 ROM reads per claimed bank, bank 0 first
// DRAIN | ROM_LAT cycles letting the write pipeline empty
// DONE  | publish col_valid, pulse done
module hud_glyph_fetch_sched #(
    parameter int NSLOT   = 12,
    parameter int ROM_LAT = 1,
    parameter int PIX_W   = 9
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               line_start,
    input  logic [9:0]         next_y,
    input  logic [4*NSLOT-1:0] slot_digit,
    output logic [13:0]        rom_addr,
    input  logic [PIX_W-1:0]   rom_q,
    input  logic [9:0]         rd_x,
    output logic [PIX_W-1:0]   rd_rgb,
    output logic               rd_hit,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ty_q, ty_d, fy_q, fy_d;
    logic [3:0]  scan_q, scan_d;
    logic [1:0]  claimed_q, claimed_d;
    logic [3:0]  dig_q [2];
    logic [3:0]  dig_d [2];
    logic        bank_q, bank_d;
    logic [4:0]  x_q, x_d;
    logic [1:0]  drain_q, drain_d;
    logic [1:0]  col_valid_q, col_valid_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic [13:0] rom_addr_q, rom_addr_d;
    logic        issue;

    // Stage 0 travels with the registered rom_addr; stage ROM_LAT lines up
    // with rom_q for that address.
    logic        pv_q [ROM_LAT+1];
    logic        pb_q [ROM_LAT+1];
    logic [4:0]  px_q [ROM_LAT+1];

    logic [PIX_W-1:0] bank0_mem [32];
    logic [PIX_W-1:0] bank1_mem [32];

    // Slot table: {bank (0 = col 17, 1 = col 18), tile row}
    function automatic logic [5:0] slot_info(input logic [3:0] i);
        case (i)
            4'd0:    slot_info = {1'b1, 5'd2};
            4'd1:    slot_info = {1'b0, 5'd2};
            4'd2:    slot_info = {1'b1, 5'd4};
            4'd3:    slot_info = {1'b0, 5'd4};
            4'd4:    slot_info = {1'b0, 5'd9};
            4'd5:    slot_info = {1'b1, 5'd9};
            4'd6:    slot_info = {1'b0, 5'd10};
            4'd7:    slot_info = {1'b1, 5'd10};
            4'd8:    slot_info = {1'b0, 5'd11};
            4'd9:    slot_info = {1'b1, 5'd11};
            4'd10:   slot_info = {1'b0, 5'd12};
            4'd11:   slot_info = {1'b1, 5'd12};
            default: slot_info = {1'b0, 5'd31};
        endcase
    endfunction

    logic [5:0] sinfo;
    logic       s_bank;
    assign sinfo  = slot_info(scan_q);
    assign s_bank = sinfo[5];

    assign busy = (state_q == S_SCAN) || (state_q == S_FETCH) || (state_q == S_DRAIN);

    always_comb begin
        state_d     = state_q;
        ty_d        = ty_q;
        fy_d        = fy_q;
        scan_d      = scan_q;
        claimed_d   = claimed_q;
        dig_d       = dig_q;
        bank_d      = bank_q;
        x_d         = x_q;
        drain_d     = drain_q;
        col_valid_d = col_valid_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q | (line_start & busy);
        rom_addr_d  = rom_addr_q;
        issue       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    ty_d        = next_y[9:5];
                    fy_d        = next_y[4:0];
                    col_valid_d = 2'b00;
                    claimed_d   = 2'b00;
                    scan_d      = 4'd0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (sinfo[4:0] == ty_q && !claimed_q[s_bank]) begin
                    claimed_d[s_bank] = 1'b1;
                    dig_d[s_bank]     = slot_digit[{scan_q, 2'b00} +: 4];
                end
                scan_d = scan_q + 4'd1;
                if (scan_q == 4'(NSLOT - 1)) begin
                    x_d = 5'd0;
                    if (claimed_d[0]) begin
                        bank_d  = 1'b0;
                        state_d = S_FETCH;
                    end else if (claimed_d[1]) begin
                        bank_d  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        drain_d = 2'(ROM_LAT - 1);
                        state_d = S_DRAIN;
                    end
                end
            end
            S_FETCH: begin
                issue      = 1'b1;
                rom_addr_d = {dig_q[bank_q], x_q, fy_q};
                x_d        = x_q + 5'd1;
                if (x_q == 5'd31) begin
                    if (!bank_q && claimed_q[1]) begin
                        bank_d = 1'b1;
                    end else begin
                        drain_d = 2'(ROM_LAT - 1);
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'd0) state_d = S_DONE;
                else                 drain_d = drain_q - 2'd1;
            end
            S_DONE: begin
                col_valid_d = claimed_q;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            ty_q        <= '0;
            fy_q        <= '0;
            scan_q      <= '0;
            claimed_q   <= '0;
            dig_q[0]    <= '0;
            dig_q[1]    <= '0;
            bank_q      <= 1'b0;
            x_q         <= '0;
            drain_q     <= '0;
            col_valid_q <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            rom_addr_q  <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                pv_q[k] <= 1'b0;
                pb_q[k] <= 1'b0;
                px_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ty_q        <= ty_d;
            fy_q        <= fy_d;
            scan_q      <= scan_d;
            claimed_q   <= claimed_d;
            dig_q       <= dig_d;
            bank_q      <= bank_d;
            x_q         <= x_d;
            drain_q     <= drain_d;
            col_valid_q <= col_valid_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            rom_addr_q  <= rom_addr_d;
            pv_q[0]     <= issue;
            pb_q[0]     <= bank_q;
            px_q[0]     <= x_q;
            for (int k = 1; k <= ROM_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pb_q[k] <= pb_q[k-1];
                px_q[k] <= px_q[k-1];
            end
        end
    end

    // Line buffer is plain RAM, contents deliberately not reset.
    always_ff @(posedge Clk) begin
        if (pv_q[ROM_LAT]) begin
            if (pb_q[ROM_LAT]) bank1_mem[px_q[ROM_LAT]] <= rom_q;
            else               bank0_mem[px_q[ROM_LAT]] <= rom_q;
        end
    end

    logic hit0, hit1;
    assign hit0   = (rd_x[9:5] == 5'd17) && col_valid_q[0];
    assign hit1   = (rd_x[9:5] == 5'd18) && col_valid_q[1];
    assign rd_hit = hit0 | hit1;
    assign rd_rgb = hit0 ? bank0_mem[rd_x[4:0]] :
                    hit1 ? bank1_mem[rd_x[4:0]] : '0;

    assign rom_addr = rom_addr_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_hud_glyph_fetch_sched.sv
module tb_hud_glyph_fetch_sched;

    logic        Clk;
    logic        Reset_n;
    logic        ls1, ls3;
    logic [9:0]  next_y;
    logic [47:0] slot_digit;
    logic [9:0]  rd_x;

    logic [13:0] rom_addr1, rom_addr3;
    logic [8:0]  rom_q1, rom_q3, r3a, r3b;
    logic [8:0]  rd_rgb1, rd_rgb3;
    logic        rd_hit1, rd_hit3, busy1, busy3, done1, done3, ovr1, ovr3;

    int checks = 0;
    int errors = 0;
    logic [13:0] hist [0:255];

    hud_glyph_fetch_sched #(.NSLOT(12), .ROM_LAT(1), .PIX_W(9)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .line_start(ls1), .next_y(next_y),
        .slot_digit(slot_digit), .rom_addr(rom_addr1), .rom_q(rom_q1),
        .rd_x(rd_x), .rd_rgb(rd_rgb1), .rd_hit(rd_hit1), .busy(busy1),
        .done(done1), .overrun(ovr1));

    hud_glyph_fetch_sched #(.NSLOT(12), .ROM_LAT(3), .PIX_W(9)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .line_start(ls3), .next_y(next_y),
        .slot_digit(slot_digit), .rom_addr(rom_addr3), .rom_q(rom_q3),
        .rd_x(rd_x), .rd_rgb(rd_rgb3), .rd_hit(rd_hit3), .busy(busy3),
        .done(done3), .overrun(ovr3));

    // Glyph ROM content model
    function automatic logic [8:0] romf(input logic [13:0] a);
        romf = a[8:0] ^ {a[13:9], a[13:10]};
    endfunction

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) begin
        rom_q1 <= romf(rom_addr1);
        r3a    <= romf(rom_addr3);
        r3b    <= r3a;
        rom_q3 <= r3b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses line_start to one DUT and counts cycles until done.
    task automatic wait_done(input bit use3, input int pulse2_at, input int chg_at,
                             input logic [47:0] chg_val, output int lat);
        int cnt = 0;
        lat = -1;
        if (use3) ls3 = 1'b1; else ls1 = 1'b1;
        while (cnt < 200 && lat < 0) begin
            @(posedge Clk); #1;
            cnt++;
            ls3 = 1'b0;
            ls1 = (!use3 && cnt == pulse2_at);
            if (cnt == chg_at) slot_digit = chg_val;
            hist[cnt] = rom_addr1;
            if ((use3 ? done3 : done1) === 1'b1) lat = cnt;
        end
        ls1 = 1'b0;
        @(posedge Clk); #1;
        chk("done_pulse_width", use3 ? done3 : done1, 0);
        chk("busy_after_done", use3 ? busy3 : busy1, 0);
    endtask

    task automatic chk_buf(input bit use3, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [4:0] fy, input bit v0, input bit v1);
        for (int x = 0; x < 32; x++) begin
            rd_x = 10'(544 + x); #1;
            chk("bank0_hit", use3 ? rd_hit3 : rd_hit1, v0);
            chk("bank0_rgb", use3 ? rd_rgb3 : rd_rgb1, v0 ? romf({d0, 5'(x), fy}) : 9'd0);
            rd_x = 10'(576 + x); #1;
            chk("bank1_hit", use3 ? rd_hit3 : rd_hit1, v1);
            chk("bank1_rgb", use3 ? rd_rgb3 : rd_rgb1, v1 ? romf({d1, 5'(x), fy}) : 9'd0);
        end
    endtask

    initial begin
        int lat;
        Reset_n    = 1'b0;
        ls1        = 1'b0;
        ls3        = 1'b0;
        next_y     = '0;
        slot_digit = '0;
        rd_x       = 10'd550;
        #2;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_overrun", ovr1, 0);
        chk("rst_hit", rd_hit1, 0);
        chk("rst_rgb", rd_rgb1, 0);
        chk("rst_rom_addr", rom_addr1, 0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Line 70: ty=2 fy=6, bank1<-slot0 digit 3, bank0<-slot1 digit 1
        next_y = 10'd70;
        slot_digit = 48'h0000_0000_A513;
        wait_done(1'b0, 0, 0, '0, lat);
        chk("lat_line70", lat, 79);
        for (int j = 0; j < 64; j++)
            chk("addr_walk", hist[14+j], (j < 32) ? {4'd1, 5'(j), 5'd6} : {4'd3, 5'(j - 32), 5'd6});
        chk("overrun_clear", ovr1, 0);
        chk_buf(1'b0, 4'd1, 4'd3, 5'd6, 1'b1, 1'b1);
        rd_x = 10'd550; #1;
        chk("rgb_550", rd_rgb1, romf({4'd1, 5'd6, 5'd6}));
        rd_x = 10'd543; #1;
        chk("hit_543", rd_hit1, 0);
        rd_x = 10'd608; #1;
        chk("hit_608", rd_hit1, 0);

        // Line 200: ty=6 has no slot
        next_y = 10'd200;
        wait_done(1'b0, 0, 0, '0, lat);
        chk("lat_noslot", lat, 15);
        for (int c = 1; c <= 15; c++)
            chk("addr_hold", hist[c], {4'd3, 5'd31, 5'd6});
        chk_buf(1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0);

        // Snapshot: slot0 changes right after it is claimed
        next_y = 10'd75;
        slot_digit = 48'h0000_0000_0025;
        wait_done(1'b0, 0, 2, 48'h0000_0000_0029, lat);
        chk("lat_snapshot", lat, 79);
        chk_buf(1'b0, 4'd2, 4'd5, 5'd11, 1'b1, 1'b1);

        // Overrun: second line_start 20 cycles in
        next_y = 10'd133;
        slot_digit = 48'h0000_0000_C411;
        wait_done(1'b0, 20, 0, '0, lat);
        chk("lat_overrun", lat, 79);
        chk("overrun_set", ovr1, 1);
        chk_buf(1'b0, 4'hC, 4'd4, 5'd5, 1'b1, 1'b1);
        repeat (5) @(posedge Clk);
        #1;
        chk("overrun_sticky", ovr1, 1);

        // Reset in the middle of FETCH
        next_y = 10'd70;
        slot_digit = 48'h0000_0000_A513;
        ls1 = 1'b1;
        @(posedge Clk); #1 ls1 = 1'b0;
        repeat (29) @(posedge Clk);
        #1;
        chk("busy_mid_fetch", busy1, 1);
        Reset_n = 1'b0;
        rd_x = 10'd550;
        #1;
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_overrun", ovr1, 0);
        chk("mid_rst_hit", rd_hit1, 0);
        chk("mid_rst_rgb", rd_rgb1, 0);
        chk("mid_rst_rom_addr", rom_addr1, 0);
        @(posedge Clk); #1 Reset_n = 1'b1;
        @(posedge Clk); #1;
        wait_done(1'b0, 0, 0, '0, lat);
        chk("lat_after_rst", lat, 79);
        chk_buf(1'b0, 4'd1, 4'd3, 5'd6, 1'b1, 1'b1);

        // ROM_LAT=3 instance, line 290: ty=9 fy=2, slot4 digit 7, slot5 digit 11
        next_y = 10'd290;
        slot_digit = 48'h0000_00B7_0000;
        wait_done(1'b1, 0, 0, '0, lat);
        chk("lat_romlat3", lat, 81);
        chk("overrun3", ovr3, 0);
        chk_buf(1'b1, 4'd7, 4'hB, 5'd2, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
